tub_scan_ctrl: RTL
==================

Name: tub_scan_ctrl

Overview:
Parametrised time-multiplexed seven-segment scanner for the common-anode digit boards. It drives one active-low digit enable at a time and supplies the matching active-low segment code decoded from packed hex data. Compared with the fixed 8-digit rotator, it adds a configurable digit count and dwell time, an anti-ghosting blank gap between digits, start/stop control, per-digit blanking and decimal points, and a frame-complete pulse. It sits between the display data registers and the board pins.

Parameters:
DIGITS, 8, number of digits scanned (2..16)
SCAN_CYCLES, 200000, clk cycles each digit stays lit (>=1)
GAP_CYCLES, 2000, clk cycles with all digits off between digits (0 = no gap)
CNT_W, 26, dwell counter width; must hold max(SCAN_CYCLES, GAP_CYCLES)-1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  start scanning; sampled only in IDLE
stop  in  1  stop scanning; go to IDLE; wins over start
digit_data  in  4*DIGITS  hex nibble per digit; digit i = [4i+3:4i]
dp_mask  in  DIGITS  1 = decimal point lit on digit i
blank_mask  in  DIGITS  1 = digit i kept dark in its slot
led_en  out  DIGITS  active-low digit enables, at most one bit low
led_seg  out  8  active-low segments {dp,g,f,e,d,c,b,a}
scan_idx  out  clog2(DIGITS)  index of the current or most recent digit
frame_done  out  1  one-cycle pulse when the index wraps DIGITS-1 -> 0

Behaviour:
- Reset (async, rst_n=0): state IDLE, led_en all 1, led_seg 8'hFF, scan_idx 0, counter 0, frame_done 0.
- States:
  - IDLE: outputs off.
  - ON: digit scan_idx is lit.
  - GAP: all digits off; scan_idx holds.
- All outputs are registered and updated on the same edge as the state/index change. No output glitches.
- IDLE -> ON on start=1 (and stop=0). scan_idx = 0, counter = 0.
- ON:
  - Lasts exactly SCAN_CYCLES clocks.
  - On the entry edge, latch the digit's nibble, dp bit and blank bit. Changes to the inputs mid-slot are ignored.
  - led_en[scan_idx] = 0 unless blank=1, in which case led_en is all 1.
  - led_seg = {~dp, decode(nibble)}. When blanked, led_seg = 8'hFF.
- ON -> GAP when counter == SCAN_CYCLES-1 and GAP_CYCLES > 0. Otherwise go directly to ON for the next index.
- GAP: lasts exactly GAP_CYCLES clocks with led_en all 1 and led_seg 8'hFF. Then ON with the next index.
- Index advance: idx+1, wrapping DIGITS-1 -> 0. frame_done is high for the single cycle in which the new ON slot for index 0 begins.
- Frame period: DIGITS*(SCAN_CYCLES+GAP_CYCLES) clocks.
- Decode, active-low g..a:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
  - Bit 7 is ~dp.
- stop=1 in any state:
  - Next edge -> IDLE, outputs off, scan_idx 0, counter 0, frame_done 0.
  - stop has priority over a simultaneous start.
  - Asserting start in ON or GAP has no effect (no restart).
- If start and stop are both held, the block remains IDLE.
- Counter resets to 0 on every state entry. No counter overflow for legal parameters.

Test Plan:
(bench uses DIGITS=4, SCAN_CYCLES=5, GAP_CYCLES=2)
- Reset with rst_n=0 mid-scan -> outputs immediately led_en=4'hF, led_seg=FF, scan_idx=0, and the block stays IDLE after release until start.
- start pulse, digit_data=16'h3210, masks 0 -> led_en goes 1110 for 5 clks (seg C0), then 1111 for 2 clks, then 1101 (seg F9), 1011 (A4), 0111 (B0). frame_done pulses once when 1110 reappears, 28 clks after the first 1110.
- dp_mask=4'b0010, blank_mask=4'b0100 -> digit1 seg=79; digit2 slot shows led_en=1111 and seg=FF for 5 clks; timing unchanged.
- Change digit_data mid-slot of digit0 -> led_seg constant for the whole slot, and the new value appears at the next digit0 slot.
- stop during GAP, and start+stop in the same cycle from IDLE -> IDLE, outputs off, scan_idx=0 on the next edge, no scanning.
- Rebuild with GAP_CYCLES=0 -> back-to-back 5-clk slots, led_en never all 1 between digits, frame period 20 clks.

Source files
------------

// File: rtl/tub_scan_ctrl.sv
// tub_scan_ctrl: time-multiplexed seven-segment scanner for common-anode
// digit boards. One active-low digit enable at a time, a configurable dwell
// per digit, an optional all-dark gap between digits against ghosting, and a
// one-cycle frame_done pulse each time the scan wraps back to digit 0.
// All outputs come straight from flops so the board pins never glitch.
module tub_scan_ctrl #(
  parameter int DIGITS      = 8,
  parameter int SCAN_CYCLES = 200000,
  parameter int GAP_CYCLES  = 2000,
  parameter int CNT_W       = 26
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       stop,
  input  logic [4*DIGITS-1:0]        digit_data,
  input  logic [DIGITS-1:0]          dp_mask,
  input  logic [DIGITS-1:0]          blank_mask,
  output logic [DIGITS-1:0]          led_en,
  output logic [7:0]                 led_seg,
  output logic [$clog2(DIGITS)-1:0]  scan_idx,
  output logic                       frame_done
);

  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam bit               HAS_GAP   = (GAP_CYCLES > 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d, idx_nxt;
  logic [DIGITS-1:0] en_q, en_d;
  logic [7:0]        seg_q, seg_d;
  logic              fd_q, fd_d;
  logic              load;
  logic [IDX_W-1:0]  load_idx;

  // Hex nibble to active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Digit enables for a slot: one bit low, or all high when the digit is blanked.
  function automatic logic [DIGITS-1:0] slot_en(input logic [IDX_W-1:0] idx,
                                                input logic blank);
    logic [DIGITS-1:0] en;
    en = '1;
    if (!blank) en[idx] = 1'b0;
    return en;
  endfunction

  // Segment code for a slot; a blanked digit keeps every segment dark too.
  function automatic logic [7:0] slot_seg(input logic [3:0] nib,
                                          input logic dp,
                                          input logic blank);
    logic [7:0] s;
    if (blank) s = 8'hFF;
    else       s = {~dp, hex_decode(nib)};
    return s;
  endfunction

  // State, counter, index and registered pin drivers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      en_q    <= '1;
      seg_q   <= 8'hFF;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      seg_q   <= seg_d;
      fd_q    <= fd_d;
    end
  end

  // Next-state logic; the digit's nibble/dp/blank are sampled only on slot entry.
  always_comb begin
    idx_nxt  = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    idx_d    = idx_q;
    en_d     = en_q;
    seg_d    = seg_q;
    fd_d     = 1'b0;
    load     = 1'b0;
    load_idx = idx_nxt;

    if (stop) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
      en_d    = '1;
      seg_d   = 8'hFF;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          if (start) begin
            state_d  = S_ON;
            idx_d    = '0;
            load     = 1'b1;
            load_idx = '0;
          end
        end
        S_ON: begin
          if (cnt_q == SCAN_LAST) begin
            cnt_d = '0;
            if (HAS_GAP) begin
              state_d = S_GAP;
              en_d    = '1;
              seg_d   = 8'hFF;
            end else begin
              idx_d = idx_nxt;
              load  = 1'b1;
              fd_d  = (idx_q == IDX_LAST);
            end
          end
        end
        S_GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_d = S_ON;
            cnt_d   = '0;
            idx_d   = idx_nxt;
            load    = 1'b1;
            fd_d    = (idx_q == IDX_LAST);
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
          en_d    = '1;
          seg_d   = 8'hFF;
        end
      endcase
    end

    if (load) begin
      en_d  = slot_en(load_idx, blank_mask[load_idx]);
      seg_d = slot_seg(digit_data[{load_idx, 2'b00} +: 4], dp_mask[load_idx],
                       blank_mask[load_idx]);
    end
  end

  assign led_en     = en_q;
  assign led_seg    = seg_q;
  assign scan_idx   = idx_q;
  assign frame_done = fd_q;

endmodule
